// File: rtl/sdp_ram_pkg.sv
// Shared constants and types for the simple dual-port RAM with registered read.
package sdp_ram_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 4;

  // Number of words addressed by an address of width aw.
  function automatic int unsigned depth_of(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

  localparam int unsigned DEPTH = depth_of(ADDR_W_DEF);

  typedef logic [DATA_W_DEF-1:0] data_t;
  typedef logic [ADDR_W_DEF-1:0] addr_t;

endpackage

// File: rtl/sdp_ram_array.sv
// Storage array: one synchronous write port, one asynchronous read mux,
// all words cleared by asynchronous reset.
module sdp_ram_array
  import sdp_ram_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addrw,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] addrr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned NWORDS = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem_q [NWORDS];
  logic [DATA_W-1:0] mem_d [NWORDS];

  // Next-state of the array: only the addressed word changes on a write.
  // An unknown wr_en takes the no-write branch, so X never fans out.
  always_comb begin
    mem_d = mem_q;
    if (wr_en == 1'b1) begin
      mem_d[addrw] = wdata;
    end
  end

  // Storage registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  // Asynchronous read mux; the caller registers the result.
  always_comb begin
    rd_data = mem_q[addrr];
  end

`ifndef SYNTHESIS
  wr_ctrl_known_a: assert property (@(posedge clk) disable iff (rst)
    !$isunknown(wr_en) && (!wr_en || !$isunknown(addrw)));
`endif

endmodule

// File: rtl/sdp_ram_regout.sv
// Simple dual-port synchronous RAM with registered read data (1-cycle latency).
// Optional macro MEM_BYPASS_EN: same-address read/write in one cycle returns
// the new write data (write-first); otherwise reads return the old word.
module sdp_ram_regout
  import sdp_ram_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addrw,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addrr,
  output logic [DATA_W-1:0] rdata,
  output logic              rd_valid
);

  logic [DATA_W-1:0] arr_rdata;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;
  logic              rd_valid_q;
  logic              rd_valid_d;

  sdp_ram_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .addrw   (addrw),
    .wdata   (wdata),
    .addrr   (addrr),
    .rd_data (arr_rdata)
  );

`ifdef MEM_BYPASS_EN
  // Forward the incoming write word when it targets the address being read.
  always_comb begin
    rd_word = arr_rdata;
    if (wr_en && rd_en && (addrw == addrr)) begin
      rd_word = wdata;
    end
  end
`else
  // Read-before-write: the array output is the pre-write word.
  always_comb begin
    rd_word = arr_rdata;
  end
`endif

  // Read register next-state: capture on rd_en, otherwise hold the last data.
  always_comb begin
    rdata_d    = rdata_q;
    rd_valid_d = 1'b0;
    if (rd_en) begin
      rdata_d    = rd_word;
      rd_valid_d = 1'b1;
    end
  end

  // Read data and valid registers; reset drops any in-flight read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rdata_q    <= rdata_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rdata    = rdata_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_sdp_ram_regout.sv
// Self-checking bench for sdp_ram_regout: directed steps from the test plan
// followed by randomized traffic, against a word-array reference model.
module tb_sdp_ram_regout;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [3:0]  addrw;
  logic [15:0] wdata;
  logic        rd_en;
  logic [3:0]  addrr;
  logic [15:0] rdata;
  logic        rd_valid;

  int checks;
  int errors;

  logic [15:0] model [16];
  logic [15:0] exp_rdata;
  logic        exp_valid;

  logic [15:0] fill_vals [8];

  sdp_ram_regout #(
    .DATA_W (16),
    .ADDR_W (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .addrw    (addrw),
    .wdata    (wdata),
    .rd_en    (rd_en),
    .addrr    (addrr),
    .rdata    (rdata),
    .rd_valid (rd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "_rdata"}, rdata, exp_rdata);
    chk({tag, "_valid"}, {15'd0, rd_valid}, {15'd0, exp_valid});
  endtask

  // One clock: apply inputs, let the edge happen, advance the model, compare.
  task automatic step(input logic we, input logic [3:0] aw, input logic [15:0] wd,
                      input logic re, input logic [3:0] ar, input string tag);
    wr_en = we; addrw = aw; wdata = wd; rd_en = re; addrr = ar;
    @(posedge clk);
    #1;
    if (re) begin
`ifdef MEM_BYPASS_EN
      exp_rdata = (we && aw == ar) ? wd : model[ar];
`else
      exp_rdata = model[ar];
`endif
      exp_valid = 1'b1;
    end else begin
      exp_valid = 1'b0;
    end
    if (we) model[aw] = wd;
    chk_outputs(tag);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) model[i] = 16'h0000;
    exp_rdata = 16'h0000;
    exp_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    wr_en = 1'b0; addrw = '0; wdata = '0; rd_en = 1'b0; addrr = '0;
    fill_vals[0] = 16'h3524; fill_vals[1] = 16'h5E81;
    fill_vals[2] = 16'hD609; fill_vals[3] = 16'h5663;
    fill_vals[4] = 16'h7B0D; fill_vals[5] = 16'h998D;
    fill_vals[6] = 16'h8465; fill_vals[7] = 16'h5212;

    // Reset then read every address.
    rst = 1'b1;
    model_clear();
    #2;
    chk_outputs("reset");
    repeat (3) @(posedge clk);
    #1;
    chk_outputs("reset_held");
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 4'd0, 16'h0, 1'b1, 4'(i), "rst_read");
      chk("rst_read_zero", rdata, 16'h0000);
    end

    // Sequential fill and readback.
    for (int i = 0; i < 8; i++) step(1'b1, 4'(i), fill_vals[i], 1'b0, 4'd0, "fill");
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 4'd0, 16'h0, 1'b1, 4'(i), "readback");
      chk("readback_lit", rdata, fill_vals[i]);
    end

    // Hold: rdata keeps the last read word while rd_en is low.
    step(1'b0, 4'd0, 16'h0, 1'b1, 4'd3, "hold_rd");
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'd0, 16'h0, 1'b0, 4'(i), "hold_idle");
      chk("hold_lit", rdata, 16'h5663);
    end

    // Same-address collision.
    step(1'b1, 4'd5, 16'h1111, 1'b0, 4'd0, "coll_pre");
    step(1'b1, 4'd5, 16'h2222, 1'b1, 4'd5, "coll");
`ifdef MEM_BYPASS_EN
    chk("coll_lit", rdata, 16'h2222);
`else
    chk("coll_lit", rdata, 16'h1111);
`endif
    step(1'b0, 4'd0, 16'h0, 1'b1, 4'd5, "coll_after");
    chk("coll_after_lit", rdata, 16'h2222);

    // Different-address read and write in the same cycle.
    step(1'b1, 4'd9, 16'hBEEF, 1'b1, 4'd1, "diff_addr");
    chk("diff_addr_lit", rdata, 16'h5E81);

    // Boundary addresses, no aliasing into 7/8.
    step(1'b1, 4'd15, 16'hFFFF, 1'b0, 4'd0, "bnd_w15");
    step(1'b1, 4'd0, 16'hA5A5, 1'b0, 4'd0, "bnd_w0");
    step(1'b0, 4'd0, 16'h0, 1'b1, 4'd15, "bnd_r15");
    chk("bnd_r15_lit", rdata, 16'hFFFF);
    step(1'b0, 4'd0, 16'h0, 1'b1, 4'd0, "bnd_r0");
    chk("bnd_r0_lit", rdata, 16'hA5A5);
    step(1'b0, 4'd0, 16'h0, 1'b1, 4'd7, "bnd_r7");
    chk("bnd_r7_lit", rdata, 16'h5212);
    step(1'b0, 4'd0, 16'h0, 1'b1, 4'd8, "bnd_r8");
    chk("bnd_r8_lit", rdata, 16'h0000);

    // Randomized traffic, including frequent same-address collisions.
    for (int n = 0; n < 300; n++) begin
      logic [3:0] ra;
      logic [3:0] wa;
      ra = 4'($urandom_range(0, 15));
      wa = ($urandom_range(0, 3) == 0) ? ra : 4'($urandom_range(0, 15));
      step(1'($urandom_range(0, 1)), wa, 16'($urandom), 1'($urandom_range(0, 1)), ra, "rand");
    end

    // Async reset mid-read: valid read captured, next read pending, reset between edges.
    step(1'b1, 4'd2, 16'hD609, 1'b0, 4'd0, "arst_prep");
    step(1'b0, 4'd0, 16'h0, 1'b1, 4'd2, "arst_rd");
    chk("arst_rd_lit", rdata, 16'hD609);
    rd_en = 1'b1; addrr = 4'd2;
    #2;
    rst = 1'b1;
    #1;
    model_clear();
    chk_outputs("arst_now");
    @(posedge clk);
    #1;
    chk_outputs("arst_held");
    rst = 1'b0;
    rd_en = 1'b0;
    @(posedge clk);
    #1;
    chk_outputs("arst_release");
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 4'd0, 16'h0, 1'b1, 4'(i), "arst_read");
      chk("arst_read_zero", rdata, 16'h0000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdp_ram_regout.md
Name: sdp_ram_regout

Overview:
- Simple dual-port synchronous RAM: one write port and one read port with independent addresses, sharing one clock.
- Read data is registered, so read latency is one clock.
- Used as small scratch/storage memory in the datapath. The default configuration is 16 words x 16 bits.

Parameters:
- DATA_W, 16, width of each stored word and of wdata/rdata.
- ADDR_W, 4, width of addrw/addrr; depth = 2**ADDR_W (16 by default).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write enable.
- addrw  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- rd_en  in  1  read enable.
- addrr  in  ADDR_W  read address.
- rdata  out  DATA_W  registered read data.
- rd_valid  out  1  high for one cycle when rdata holds the result of a read issued the previous cycle.

Behaviour:
- Reset (rst=1, asynchronous assert): all 2**ADDR_W storage words become 0, rdata=0, rd_valid=0.
  - Reset is held for as long as rst=1; release is synchronous to clk.
  - Reset mid-operation discards any in-flight read: rd_valid=0 and rdata=0 on the first cycle after release.
- Write: at a rising edge with wr_en=1, mem[addrw] <= wdata.
  - wr_en=0: no storage change.
  - Write latency: visible to a read issued on the next cycle.
- Read: at a rising edge with rd_en=1, rdata <= mem[addrr] and rd_valid <= 1.
  - The data is available one cycle after the read request.
- Read idle: with rd_en=0, rdata holds its last value (it does not return to 0) and rd_valid <= 0.
- Addresses: full ADDR_W decode, no wrap logic needed; every address value 0..2**ADDR_W-1 is legal.
- Simultaneous read and write, different addresses: both complete independently in the same cycle.
- Simultaneous read and write, same address, without MEM_BYPASS_EN: read-before-write. rdata returns the old stored word, and the new word is stored.
- X-propagation: unknown wr_en/addrw must not silently corrupt other words in simulation. The write enable is gated on known values, or an assertion fires.
- No handshake/backpressure: the port accepts one read and one write every cycle.

Optional Feature:
- Macro MEM_BYPASS_EN.
- Defined: same-cycle read/write to the same address with both enables high returns wdata on rdata (write-first forwarding), one cycle later as usual. Storage is still updated.
- Not defined: read-before-write as stated in Behaviour; no forwarding mux is synthesized.

Decomposition:
- Shared package sdp_ram_pkg holds:
  - default constants DATA_W_DEF=16 and ADDR_W_DEF=4;
  - derived DEPTH = 2**ADDR_W;
  - typedefs for data word and address.
- One natural sub-module: sdp_ram_array, containing the storage array with its write port and an asynchronous read mux.
- The top level contains the read register, rd_valid, the optional bypass comparator/mux, and reset handling.

Test Plan:
- Reset then read: assert rst, release, read addresses 0..15 -> rdata=0x0000 each, with rd_valid high one cycle after each rd_en.
- Sequential fill/readback: write addr 0..7 with 0x3524, 0x5E81, 0xD609, 0x5663, 0x7B0D, 0x998D, 0x8465, 0x5212, then read 0..7 -> the identical values in order, each with 1-cycle latency.
- Hold: read addr 3 (0x5663), then deassert rd_en for 5 cycles -> rdata stays 0x5663 and rd_valid=0 throughout.
- Same-address collision: mem[5]=0x1111; in one cycle write 0x2222 to addr 5 and read addr 5.
  - Without MEM_BYPASS_EN: rdata=0x1111.
  - With MEM_BYPASS_EN: rdata=0x2222.
  - Either way, the next read of addr 5 gives 0x2222.
- Boundary addresses: write 0xFFFF to addr 15 and 0xA5A5 to addr 0, read both -> exact values, with no aliasing into addr 7/8.
- Async reset mid-read: issue rd_en for addr 2, assert rst between edges -> rdata=0 and rd_valid=0 immediately; after release, all words read 0.
